// File: rtl/cmp_sort_sequencer.sv
// Batch sorter: loads DEPTH words, bubble-sorts them in place with one shared
// comparator (one compare per cycle, early exit), then streams them out ascending.

module N_bit_comparator #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
endmodule

module cmp_sort_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t        state_q;
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] pass_q;
    logic          swapped_q;
    logic [N-1:0]  mem_q [DEPTH];

    logic [IW-1:0] i_next;
    logic          cmp_gt;
    logic          cmp_lt;
    logic          cmp_eq;
    logic          do_swap;
    logic          load_en;
    logic          pass_end;

    assign i_next = i_q + 1'b1;

    N_bit_comparator #(.N(N)) u_cmp (
        .a_i  (mem_q[i_q]),
        .b_i  (mem_q[i_next]),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    // Only a strict greater-than swaps; equal keys stay put, which keeps the sort stable.
    assign do_swap  = (state_q == SORT) && cmp_gt && !(cmp_lt || cmp_eq);
    assign load_en  = (state_q == LOAD) && in_valid;
    assign pass_end = (i_q == (LAST_PASS - pass_q));

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == SORT);
    assign out_data  = mem_q[rd_idx_q];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[wr_idx_q] <= in_data;
        end else if (do_swap) begin
            mem_q[i_q]    <= mem_q[i_next];
            mem_q[i_next] <= mem_q[i_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            i_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (wr_idx_q == LAST_IDX) begin
                            state_q   <= SORT;
                            wr_idx_q  <= '0;
                            pass_q    <= '0;
                            i_q       <= '0;
                            swapped_q <= 1'b0;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (pass_end) begin
                        // A clean pass means the batch is already ordered.
                        if (!(swapped_q || do_swap) || (pass_q == LAST_PASS)) begin
                            state_q  <= DRAIN;
                            rd_idx_q <= '0;
                        end else begin
                            pass_q    <= pass_q + 1'b1;
                            i_q       <= '0;
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        i_q       <= i_next;
                        swapped_q <= swapped_q || do_swap;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_q  <= LOAD;
                            rd_idx_q <= '0;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_sort_sequencer.sv
// Directed bench for cmp_sort_sequencer: a DEPTH=4 and a DEPTH=8 instance share
// clock, reset, data and out_ready; a select chooses which one a step exercises.

module tb_cmp_sort_sequencer;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_valid4, in_valid8;
    logic       in_ready4, in_ready8;
    logic       out_valid4, out_valid8;
    logic       busy4, busy8;
    logic [7:0] out_data4, out_data8;
    logic       sel8;

    logic       cur_in_ready, cur_out_valid, cur_busy;
    logic [7:0] cur_out_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] batch[8];

    cmp_sort_sequencer #(.N(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .busy(busy4)
    );

    cmp_sort_sequencer #(.N(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_in_ready  = sel8 ? in_ready8  : in_ready4;
        cur_out_valid = sel8 ? out_valid8 : out_valid4;
        cur_busy      = sel8 ? busy8      : busy4;
        cur_out_data  = sel8 ? out_data8  : out_data4;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive batch[0..n-1]; the scoreboard receives the ascending order of the batch.
    task automatic load_batch(input int n, input bit rnd);
        logic [7:0] srt[8];
        logic [7:0] tmp;
        int  k;
        int  guard;
        bit  v;
        bit  acc;
        for (int a = 0; a < n; a++) srt[a] = batch[a];
        for (int a = 1; a < n; a++)
            for (int b = a; b > 0 && srt[b-1] > srt[b]; b--) begin
                tmp = srt[b]; srt[b] = srt[b-1]; srt[b-1] = tmp;
            end
        for (int a = 0; a < n; a++) exp_q.push_back(srt[a]);
        k = 0;
        guard = 0;
        while (k < n && guard < 200) begin
            in_data = batch[k];
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel8) in_valid8 = v; else in_valid4 = v;
            if (rnd && !sel8) check("wr_idx_hold", 32'(dut4.wr_idx_q), 32'(k));
            acc = v && cur_in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        check("load_done", 32'(k), 32'(n));
    endtask

    task automatic wait_sort(output int cycles, input bit chk_eq);
        cycles = 0;
        check("busy_rise", 32'(cur_busy), 1);
        while (cur_busy && cycles < 200) begin
            if (chk_eq) check("eq_no_swap", 32'(dut8.cmp_eq & dut8.do_swap), 0);
            @(posedge clk); #1;
            cycles++;
        end
        check("sort_bounded", 32'(cycles < 200), 1);
        check("drain_first_cycle", 32'(cur_out_valid), 1);
    endtask

    task automatic drain(input int n, input int hold_at);
        int         k;
        int         guard;
        logic [7:0] held;
        logic [7:0] e;
        k = 0;
        guard = 0;
        while (k < n && guard < 300) begin
            guard++;
            if (!cur_out_valid) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
            end else begin
                if (k == hold_at) begin
                    out_ready = 1'b0;
                    held = cur_out_data;
                    repeat (5) begin
                        @(posedge clk); #1;
                        check("bp_data_stable", 32'(cur_out_data), 32'(held));
                        check("bp_in_ready_low", 32'(cur_in_ready), 0);
                        check("bp_out_valid", 32'(cur_out_valid), 1);
                    end
                end
                check("sb_nonempty", 32'(exp_q.size() > 0), 1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("out_data", 32'(cur_out_data), 32'(e));
                out_ready = 1'b1;
                @(posedge clk); #1;
                k++;
            end
        end
        out_ready = 1'b0;
        check("drain_count", 32'(k), 32'(n));
        check("in_ready_after_drain", 32'(cur_in_ready), 1);
        check("out_valid_after_drain", 32'(cur_out_valid), 0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        sel8      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready4", 32'(in_ready4), 1);
        check("rst_out_valid4", 32'(out_valid4), 0);
        check("rst_busy4", 32'(busy4), 0);
        check("rst_in_ready8", 32'(in_ready8), 1);
        check("rst_busy8", 32'(busy8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reverse input: 6 compares, then 1,2,3,4.
        batch = '{4, 3, 2, 1, 0, 0, 0, 0};
        load_batch(4, 1'b0);
        wait_sort(cyc, 1'b0);
        check("reverse_sort_cycles", 32'(cyc), 6);
        drain(4, -1);

        // Already sorted: single pass of 3 compares.
        batch = '{1, 2, 3, 4, 0, 0, 0, 0};
        load_batch(4, 1'b0);
        wait_sort(cyc, 1'b0);
        check("sorted_sort_cycles", 32'(cyc), 3);
        drain(4, -1);

        // Backpressure on both sides.
        batch = '{2, 4, 1, 3, 0, 0, 0, 0};
        load_batch(4, 1'b1);
        wait_sort(cyc, 1'b0);
        drain(4, 1);

        // Reset in the middle of pass 1.
        batch = '{4, 3, 2, 1, 0, 0, 0, 0};
        load_batch(4, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("pass1_reached", 32'(dut4.pass_q), 1);
        check("busy_before_reset", 32'(busy4), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy4), 0);
        check("midrst_out_valid", 32'(out_valid4), 0);
        check("midrst_in_ready", 32'(in_ready4), 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        batch = '{9, 8, 7, 6, 0, 0, 0, 0};
        load_batch(4, 1'b0);
        wait_sort(cyc, 1'b0);
        drain(4, -1);

        // DEPTH=8: duplicates and extremes, never swapping equal keys.
        sel8 = 1'b1;
        batch = '{255, 0, 7, 7, 128, 0, 255, 1};
        load_batch(8, 1'b0);
        wait_sort(cyc, 1'b1);
        check("dup_sort_cycles_max", 32'(cyc <= 28), 1);
        drain(8, -1);

        // Back-to-back random batches.
        for (int a = 0; a < 8; a++) batch[a] = 8'($urandom_range(0, 255));
        load_batch(8, 1'b0);
        wait_sort(cyc, 1'b1);
        drain(8, -1);
        for (int a = 0; a < 8; a++) batch[a] = 8'($urandom_range(0, 15));
        load_batch(8, 1'b0);
        wait_sort(cyc, 1'b1);
        drain(8, -1);
        check("sb_empty_end", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmp_sort_sequencer.md
# cmp_sort_sequencer

Sequencer that time-shares one `N_bit_comparator` instance to sort a block of `DEPTH` unsigned words in ascending order. It uses bubble sort with early exit and performs one comparison per cycle. Words stream in and out over valid/ready handshakes. The block sits between a producer and a consumer that need small sorted batches, such as a top-k or median stage.

## Interface
- `N`, default 8: word width in bits; passed through to the comparator instance.
- `DEPTH`, default 8: words per batch; must be ≥2. Index width is `$clog2(DEPTH)`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  N  unsigned input word.
- `out_valid`  out  1  `out_data` holds a sorted word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  N  sorted output word, smallest first.
- `busy`  out  1  high while in SORT.

## Operation
- Storage is a `DEPTH`-entry register array `mem`. The array is not reset; its contents are don't-care after reset.
- FSM states are LOAD, SORT and DRAIN. Reset state is LOAD.
- LOAD:
  - `in_ready`=1.
  - On each cycle with `in_valid && in_ready`, the block writes `mem[wr_idx]` and increments `wr_idx`.
  - On the accept of word `DEPTH-1`, next state is SORT. `wr_idx`→0, `pass`→0, `i`→0, `swapped`→0.
- SORT:
  - `in_ready`=0, `out_valid`=0, `busy`=1.
  - Each cycle the comparator sees a=`mem[i]`, b=`mem[i+1]`.
  - If G=1, the block swaps the two entries at the clock edge and sets `swapped`.
  - If L or E, there is no swap, so equal keys keep their input order (stable sort).
  - Pass `p` covers `i`=0..`DEPTH-2-p`, which is `DEPTH-1-p` compares.
  - At the last compare of a pass:
    - If the pass had no swap (`swapped` including the current cycle is 0), or `p`=`DEPTH-2`, next state is DRAIN with `rd_idx`→0.
    - Otherwise `p`+1, `i`→0, `swapped`→0.
- DRAIN:
  - `out_valid`=1 and `out_data`=`mem[rd_idx]`.
  - On `out_valid && out_ready`, `rd_idx`+1.
  - On the handshake of word `DEPTH-1`, next state is LOAD with `rd_idx`→0.
- Outputs:
  - `in_ready` = (state==LOAD).
  - `out_valid` = (state==DRAIN).
  - `busy` = (state==SORT).
  - All three are decoded from the state register only, with no combinational path from inputs.
  - `out_data` comes from `mem[rd_idx]` only.
- Reset mid-operation, in any state: the block immediately returns to LOAD, clears all indices and flags, drives `out_valid`=0, `busy`=0 and `in_ready`=1 once `rst_n` is high, and discards the partial batch.

## Timing
- Load takes `DEPTH` accept cycles minimum. SORT is entered on the cycle after the final accept.
- Sort length:
  - Best case is `DEPTH-1` cycles (input already sorted, one pass).
  - Worst case is `DEPTH*(DEPTH-1)/2` cycles (input reverse sorted).
  - For `DEPTH`=8 this is 7 to 28 cycles.
- DRAIN is entered on the cycle after the final compare, and `out_valid` is high in that first DRAIN cycle.
- Drain takes `DEPTH` cycles minimum. LOAD re-enters the cycle after the last output handshake.
- Backpressure:
  - While `out_valid && !out_ready`, `out_data` and `rd_idx` hold.
  - While `in_valid`=0, `wr_idx` holds. There is no timeout in either case.
- Overlap: no input is accepted during SORT or DRAIN, and no output is produced during LOAD or SORT.

## Test plan
- Reverse input, `DEPTH`=4, `N`=8: load 4,3,2,1 with `in_valid` held high in cycles 0–3.
  - `busy` is high in cycles 4–9 (6 compares).
  - `out_valid` rises in cycle 10.
  - Output is 1,2,3,4 with `out_ready`=1.
- Sorted input, `DEPTH`=4: load 1,2,3,4.
  - Exactly 3 SORT cycles (4–6).
  - DRAIN in cycle 7.
  - Output is 1,2,3,4.
- Duplicates and extremes, `DEPTH`=8: load 255,0,7,7,128,0,255,1.
  - Output is 0,0,1,7,7,128,255,255.
  - No swap ever occurs on an equal pair; check that the comparator E output never coincides with a swap.
- Backpressure, `DEPTH`=4:
  - Toggle `in_valid` randomly during LOAD; confirm `wr_idx` only advances on accept.
  - Hold `out_ready`=0 for 5 cycles in DRAIN; `out_data` must stay stable and `in_ready` must stay 0.
- Reset mid-SORT: assert `rst_n`=0 during pass 1.
  - `busy`=0, `out_valid`=0 and state LOAD immediately.
  - After release, a fresh batch of 9,8,7,6 drains as 6,7,8,9.
- Back-to-back batches, `DEPTH`=8: drain batch 1 with `out_ready`=1 and load batch 2 immediately.
  - `in_ready` rises the cycle after the last output handshake.
  - Batch 2 is sorted independently with no carry-over.
